// File: rtl/ss_div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package ss_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_SIZE_DATA  = 32;
    localparam int DEF_RADIX_BITS = 1;

    function automatic int calc_iters(input int size_data, input int radix_bits);
        return size_data / radix_bits;
    endfunction

    function automatic int calc_cnt_w(input int size_data, input int radix_bits);
        return $clog2(size_data / radix_bits + 1);
    endfunction

endpackage

// File: rtl/ss_divider_iter_if.sv
// Request/response handshake bundle between a divider client and the divider.
interface ss_divider_iter_if
    import ss_div_pkg::*;
#(
    parameter int SIZE_DATA = DEF_SIZE_DATA
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_signed;
    logic [SIZE_DATA-1:0] req_dividend;
    logic [SIZE_DATA-1:0] req_divisor;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [SIZE_DATA-1:0] rsp_quotient;
    logic [SIZE_DATA-1:0] rsp_remainder;
    logic                 rsp_div_by_zero;
    logic                 rsp_overflow;

    modport slave (
        input  req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_by_zero, rsp_overflow
    );

    modport master (
        output req_valid, req_signed, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div_by_zero, rsp_overflow
    );
endinterface

// File: rtl/ss_div_step.sv
// One combinational restoring-division step on magnitudes.
module ss_div_step #(
    parameter int SIZE_DATA = 32
) (
    input  logic [SIZE_DATA-1:0] i_rem,
    input  logic [SIZE_DATA-1:0] i_divisor,
    input  logic                 i_bit,
    output logic [SIZE_DATA-1:0] o_rem,
    output logic                 o_qbit
);
    logic [SIZE_DATA:0] w_shifted;

    // The remainder is always below the divisor, so the subtracted value fits SIZE_DATA bits.
    assign w_shifted = {i_rem, i_bit};
    assign o_qbit    = (w_shifted >= {1'b0, i_divisor});
    assign o_rem     = o_qbit ? (w_shifted[SIZE_DATA-1:0] - i_divisor) : w_shifted[SIZE_DATA-1:0];
endmodule

// File: rtl/ss_divider_iter.sv
// Iterative signed/unsigned divider, RADIX_BITS quotient bits per cycle, with flush and backpressure.
module ss_divider_iter
    import ss_div_pkg::*;
#(
    parameter int SIZE_DATA  = DEF_SIZE_DATA,
    parameter int RADIX_BITS = DEF_RADIX_BITS
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    ss_divider_iter_if.slave   bus
);
    localparam int                   N        = calc_iters(SIZE_DATA, RADIX_BITS);
    localparam int                   CNT_W    = calc_cnt_w(SIZE_DATA, RADIX_BITS);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(N);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [SIZE_DATA-1:0] MIN_VAL  = {1'b1, {(SIZE_DATA-1){1'b0}}};

    function automatic logic [SIZE_DATA-1:0] cond_neg(input logic neg, input logic [SIZE_DATA-1:0] v);
        return neg ? (~v + SIZE_DATA'(1)) : v;
    endfunction

    state_t                 r_state, w_next;
    logic                   w_ready, w_accept, w_zero, w_ovf_case;
    logic                   w_dvd_neg, w_dvs_neg;
    logic [SIZE_DATA-1:0]   w_dvd_mag, w_dvs_mag;
    logic [CNT_W-1:0]       r_cnt;
    logic [SIZE_DATA-1:0]   r_quo, r_dvs, r_rem;
    logic                   r_sign_q, r_sign_r;
    logic [SIZE_DATA-1:0]   r_quotient, r_remainder;
    logic                   r_dbz, r_ovf;
    logic [SIZE_DATA-1:0]   w_rem [RADIX_BITS+1];
    logic [RADIX_BITS-1:0]  w_qbits;

    assign w_zero     = (bus.req_divisor == '0);
    assign w_ovf_case = bus.req_signed && (bus.req_dividend == MIN_VAL) && (bus.req_divisor == '1);
    assign w_dvd_neg  = bus.req_signed & bus.req_dividend[SIZE_DATA-1];
    assign w_dvs_neg  = bus.req_signed & bus.req_divisor[SIZE_DATA-1];
    assign w_dvd_mag  = cond_neg(w_dvd_neg, bus.req_dividend);
    assign w_dvs_mag  = cond_neg(w_dvs_neg, bus.req_divisor);

    // Step k consumes dividend bit SIZE_DATA-1-k; earlier steps give more significant quotient bits.
    assign w_rem[0] = r_rem;
    for (genvar k = 0; k < RADIX_BITS; k++) begin : g_step
        ss_div_step #(.SIZE_DATA(SIZE_DATA)) u_step (
            .i_rem     (w_rem[k]),
            .i_divisor (r_dvs),
            .i_bit     (r_quo[SIZE_DATA-1-k]),
            .o_rem     (w_rem[k+1]),
            .o_qbit    (w_qbits[RADIX_BITS-1-k])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_ready  = ((r_state == IDLE) || ((r_state == DONE) && bus.rsp_ready)) && !i_flush;
        w_accept = bus.req_valid && w_ready;
        w_next   = r_state;
        if (i_flush) begin
            w_next = IDLE;
        end else if (w_accept) begin
            w_next = (w_zero || w_ovf_case) ? DONE : CALC;
        end else begin
            case (r_state)
                CALC:    if (r_cnt == CNT_ONE) w_next = FIX;
                FIX:     w_next = DONE;
                DONE:    if (bus.rsp_ready) w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    // Iteration working registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_quo    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_rem    <= '0;
            r_sign_q <= w_dvd_neg ^ w_dvs_neg;
            r_sign_r <= w_dvd_neg;
        end else if (r_state == CALC) begin
            r_rem <= w_rem[RADIX_BITS];
            r_quo <= {r_quo[SIZE_DATA-RADIX_BITS-1:0], w_qbits};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
            r_dbz <= w_zero;
            r_ovf <= w_ovf_case;
            if (w_zero) begin
                r_quotient  <= '1;
                r_remainder <= bus.req_dividend;
            end else if (w_ovf_case) begin
                r_quotient  <= MIN_VAL;
                r_remainder <= '0;
            end
        end else if (!i_flush) begin
            if (r_state == CALC) r_cnt <= r_cnt - CNT_ONE;
            if (r_state == FIX) begin
                r_quotient  <= cond_neg(r_sign_q, r_quo);
                r_remainder <= cond_neg(r_sign_r, r_rem);
            end
        end
    end

    assign bus.req_ready       = w_ready;
    assign bus.rsp_valid       = (r_state == DONE);
    assign bus.rsp_quotient    = r_quotient;
    assign bus.rsp_remainder   = r_remainder;
    assign bus.rsp_div_by_zero = r_dbz;
    assign bus.rsp_overflow    = r_ovf;
endmodule

// File: tb/tb_ss_divider_iter.sv
// Bench for ss_divider_iter: radix-2 and radix-4 instances against a transaction-level model.
module tb_ss_divider_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         d_valid = 1'b0, d_sgn = 1'b0, d_rready = 1'b1, d_flush = 1'b0;
    logic [W-1:0] d_a = '0, d_b = '0;

    ss_divider_iter_if #(.SIZE_DATA(W)) if1 ();
    ss_divider_iter_if #(.SIZE_DATA(W)) if2 ();

    assign if1.req_valid    = d_valid && !sel;
    assign if2.req_valid    = d_valid && sel;
    assign if1.req_signed   = d_sgn;
    assign if2.req_signed   = d_sgn;
    assign if1.req_dividend = d_a;
    assign if2.req_dividend = d_a;
    assign if1.req_divisor  = d_b;
    assign if2.req_divisor  = d_b;
    assign if1.rsp_ready    = sel ? 1'b1 : d_rready;
    assign if2.rsp_ready    = sel ? d_rready : 1'b1;

    ss_divider_iter #(.SIZE_DATA(W), .RADIX_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(d_flush && !sel), .bus(if1));
    ss_divider_iter #(.SIZE_DATA(W), .RADIX_BITS(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(d_flush && sel), .bus(if2));

    logic         o_valid, o_ready, o_dbz, o_ovf;
    logic [W-1:0] o_q, o_r;
    assign o_valid = sel ? if2.rsp_valid       : if1.rsp_valid;
    assign o_ready = sel ? if2.req_ready       : if1.req_ready;
    assign o_dbz   = sel ? if2.rsp_div_by_zero : if1.rsp_div_by_zero;
    assign o_ovf   = sel ? if2.rsp_overflow    : if1.rsp_overflow;
    assign o_q     = sel ? if2.rsp_quotient    : if1.rsp_quotient;
    assign o_r     = sel ? if2.rsp_remainder   : if1.rsp_remainder;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: integer division truncated toward zero, plus the two special results.
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output logic ovf);
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0; ovf = 1'b1;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Inputs are sampled just before each rising edge, outputs checked just after it.
    initial begin : p_mon
        int           cyc, due, n_iter;
        bit           busy, vld, exp_rdy, acc;
        logic [W-1:0] eq, er, pq, pr, s_a, s_b;
        logic         edbz, eovf, nd, nv;
        logic         s_rst, s_valid, s_ready, s_rready, s_flush, s_sgn;
        cyc = 0; due = 0; busy = 0; vld = 0;
        eq = '0; er = '0; pq = '0; pr = '0; edbz = 0; eovf = 0;
        forever begin
            @(negedge clk);
            #4;
            s_rst = rst_n; s_valid = d_valid; s_ready = o_ready; s_rready = d_rready;
            s_flush = d_flush; s_sgn = d_sgn; s_a = d_a; s_b = d_b;
            n_iter = sel ? 16 : 32;
            @(posedge clk);
            cyc++;
            #1;
            if (!s_rst) begin
                busy = 0; vld = 0; eq = '0; er = '0; edbz = 0; eovf = 0;
            end else begin
                exp_rdy = !s_flush && ((!busy && !vld) || (vld && s_rready));
                chk("o_ready", s_ready, exp_rdy);
                acc = s_valid && exp_rdy;
                if (s_flush) begin
                    busy = 0; vld = 0;
                end else begin
                    if (vld && s_rready) vld = 0;
                    if (acc) begin
                        model(s_sgn, s_a, s_b, pq, pr, nd, nv);
                        edbz = nd; eovf = nv;
                        if (nd || nv) begin
                            vld = 1; eq = pq; er = pr;
                        end else begin
                            busy = 1; due = cyc + n_iter + 1;
                        end
                    end else if (busy && cyc == due) begin
                        busy = 0; vld = 1; eq = pq; er = pr;
                    end
                end
            end
            chk("o_valid", o_valid, vld);
            chk("o_quotient", o_q, eq);
            chk("o_remainder", o_r, er);
            chk("o_div_by_zero", o_dbz, edbz);
            chk("o_overflow", o_ovf, eovf);
        end
    end

    task automatic wait_res(input string name, input logic [W-1:0] xq, input logic [W-1:0] xr,
                            input logic xdbz, input logic xovf, input int xlat);
        int lat;
        bit got;
        got = 0;
        for (lat = 1; lat <= 100; lat++) begin
            if (o_valid) begin got = 1; break; end
            @(negedge clk);
        end
        chk({name, " valid_seen"}, got, 1);
        chk({name, " latency"}, lat, xlat);
        chk({name, " q"}, o_q, xq);
        chk({name, " r"}, o_r, xr);
        chk({name, " dbz"}, o_dbz, xdbz);
        chk({name, " ovf"}, o_ovf, xovf);
    endtask

    task automatic do_op(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] xq, input logic [W-1:0] xr,
                         input logic xdbz, input logic xovf, input int xlat);
        d_sgn = sgn; d_a = a; d_b = b; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        wait_res(name, xq, xr, xdbz, xovf, xlat);
    endtask

    task automatic run_random(input int cnt);
        int k;
        for (int i = 0; i < cnt; i++) begin
            d_sgn = $urandom_range(0, 1);
            d_a = $urandom;
            d_b = $urandom;
            case ($urandom_range(0, 9))
                0: d_b = '0;
                1: d_b = '1;
                2: d_b = 32'd1;
                3: begin d_a = 32'h8000_0000; d_b = '1; end
                4: d_a = 32'h8000_0000;
                5: begin d_a = $urandom_range(0, 1000); d_b = $urandom_range(1, 50); end
                6: d_b = $urandom_range(1, 7) * ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1);
                default: ;
            endcase
            d_valid = 1'b1;
            for (k = 0; k < 300; k++) begin
                d_rready = ($urandom_range(0, 2) != 0);
                d_flush  = ($urandom_range(0, 60) == 0);
                #4;
                if (o_ready) begin @(negedge clk); break; end
                @(negedge clk);
            end
            d_valid = 1'b0;
            d_flush = 1'b0;
            chk("rand accept_timeout", (k >= 300), 0);
            if (i == cnt / 2) begin
                repeat (5) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 3)) begin
                d_rready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
            end
        end
        d_rready = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_ready", o_ready, 1);
        chk("reset q", o_q, 0);
        chk("reset r", o_r, 0);
        chk("reset dbz", o_dbz, 0);
        chk("reset ovf", o_ovf, 0);

        do_op("u100/7",   0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 34);
        do_op("umax/1",   0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 34);
        do_op("s-7/2",    1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 34);
        do_op("s7/-2",    1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 0, 34);
        do_op("s-7/-2",   1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0, 0, 34);
        do_op("u123/0",   0, 32'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, 1, 0, 1);
        do_op("sMIN/-1",  1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 1, 1);

        @(negedge clk);
        d_rready = 1'b0;
        do_op("bp 1000/7", 0, 32'd1000, 32'd7, 32'd142, 32'd6, 0, 0, 34);
        repeat (10) begin
            @(negedge clk);
            chk("bp hold valid", o_valid, 1);
            chk("bp hold ready", o_ready, 0);
            chk("bp hold q", o_q, 32'd142);
            chk("bp hold r", o_r, 32'd6);
        end
        d_rready = 1'b1; d_valid = 1'b1; d_sgn = 1'b0; d_a = 32'd50; d_b = 32'd5;
        #1;
        chk("b2b ready", o_ready, 1);
        @(negedge clk);
        d_valid = 1'b0;
        chk("b2b valid drop", o_valid, 0);
        wait_res("b2b 50/5", 32'd10, 32'd0, 0, 0, 34);

        @(negedge clk);
        d_sgn = 1'b0; d_a = 32'd12345; d_b = 32'd67; d_valid = 1'b1;
        @(negedge clk);
        d_valid = 1'b0;
        repeat (9) @(negedge clk);
        d_flush = 1'b1;
        @(negedge clk);
        d_flush = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("flush no valid", o_valid, 0);
            chk("flush keep q", o_q, 32'd10);
        end
        do_op("post-flush 99/9", 0, 32'd99, 32'd9, 32'd11, 32'd0, 0, 0, 34);

        @(negedge clk);
        sel = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("r4 1000/33", 0, 32'd1000, 32'd33, 32'd30, 32'd10, 0, 0, 18);
        do_op("r4 s-7/2",   1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 18);
        @(negedge clk);
        run_random(150);

        sel = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_random(150);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
